// File: rtl/eq_pkg.sv
// Shared types and constants for the biquad band sequencer.
// Widths, coefficient select encoding, sequencer states, Q16 saturation.
package eq_pkg;

  localparam int COEF_W    = 18;
  localparam int SAMPLE_W  = 24;
  localparam int ACC_W     = 48;
  localparam int FRAC_BITS = 16;
  localparam int NUM_TAPS  = 5;

  typedef enum logic [2:0] {
    SEL_B0 = 3'd0,
    SEL_B1 = 3'd1,
    SEL_B2 = 3'd2,
    SEL_A1 = 3'd3,
    SEL_A2 = 3'd4
  } coef_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic signed [COEF_W-1:0] COEF_ONE = 18'sh10000;

  localparam logic signed [ACC_W-1:0] SAT_MAX = 48'sh7FFFFF;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -48'sh800000;

  function automatic logic signed [SAMPLE_W-1:0] sat_q16(
    input logic signed [ACC_W-1:0] a
  );
    logic signed [ACC_W-1:0] s;
    s = a >>> FRAC_BITS;
    if (s > SAT_MAX)
      return SAMPLE_W'(SAT_MAX);
    else if (s < SAT_MIN)
      return SAMPLE_W'(SAT_MIN);
    return s[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/eq_coef_bank.sv
// Coefficient storage: 5 taps per band, active bank plus optional
// shadow bank when COEFF_SHADOW_EN is defined.
module eq_coef_bank
  import eq_pkg::*;
#(
  parameter int NUM_BANDS = 4
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     we_i,
  input  logic [2:0]               wband_i,
  input  logic [2:0]               wsel_i,
  input  logic [COEF_W-1:0]        wdata_i,
  input  logic                     commit_i,
  input  logic                     swap_i,
  output logic                     pending_o,
  input  logic [2:0]               rd_band_i,
  input  logic [2:0]               rd_sel_i,
  output logic signed [COEF_W-1:0] rd_coef_o
);

  localparam int N  = NUM_TAPS * NUM_BANDS;
  localparam int IW = $clog2(N);

  logic signed [COEF_W-1:0] act_q [N];
  logic                     wr_ok;
  logic [IW-1:0]            widx;
  logic [IW-1:0]            ridx;

  function automatic logic signed [COEF_W-1:0] rst_coef(input int i);
    return (i % NUM_TAPS == 0) ? COEF_ONE : '0;
  endfunction

  assign wr_ok = we_i && (wsel_i <= 3'(SEL_A2))
              && (int'(wband_i) < NUM_BANDS);
  assign widx  = IW'(int'(wband_i) * NUM_TAPS + int'(wsel_i));
  assign ridx  = IW'(int'(rd_band_i) * NUM_TAPS + int'(rd_sel_i));

  assign rd_coef_o = act_q[ridx];

`ifdef COEFF_SHADOW_EN
  logic signed [COEF_W-1:0] shd_q [N];
  logic                     pend_q;
  logic                     pend_d;
  logic                     do_swap;

  // A commit on the swap edge re-arms pending so a same-cycle write lands.
  assign do_swap = swap_i && pend_q;
  assign pend_d  = commit_i || (pend_q && !swap_i);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < N; i++) begin
        act_q[i] <= rst_coef(i);
        shd_q[i] <= rst_coef(i);
      end
      pend_q <= 1'b0;
    end else begin
      if (wr_ok)
        shd_q[widx] <= wdata_i;
      if (do_swap)
        act_q <= shd_q;
      pend_q <= pend_d;
    end
  end

  assign pending_o = pend_q;
`else
  logic unused;
  assign unused = commit_i ^ swap_i;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < N; i++)
        act_q[i] <= rst_coef(i);
    end else if (wr_ok) begin
      act_q[widx] <= wdata_i;
    end
  end

  assign pending_o = 1'b0;
`endif

endmodule

// File: rtl/biquad_band_sequencer.sv
// Time-multiplexed cascade of DF-I biquads, one multiply per cycle.
// Optional shadow coefficient bank via COEFF_SHADOW_EN.
module biquad_band_sequencer
  import eq_pkg::*;
#(
  parameter int NUM_BANDS = 4
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_out_valid,
  output logic                busy,
  output logic                overrun,
  input  logic                coef_we,
  input  logic [2:0]          coef_band,
  input  logic [2:0]          coef_sel,
  input  logic [COEF_W-1:0]   coef_wdata,
  input  logic                coef_commit,
  output logic                coef_pending
);

  localparam int BW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;

  state_e                     state_q, state_d;
  logic [2:0]                 step_q, step_d;
  logic [BW-1:0]              band_q, band_d;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [SAMPLE_W-1:0] x_q;
  logic signed [SAMPLE_W-1:0] x1_q [NUM_BANDS];
  logic signed [SAMPLE_W-1:0] x2_q [NUM_BANDS];
  logic signed [SAMPLE_W-1:0] y1_q [NUM_BANDS];
  logic signed [SAMPLE_W-1:0] y2_q [NUM_BANDS];
  logic [SAMPLE_W-1:0]        out_q;
  logic                       out_vld_q;
  logic                       ovr_q;

  logic signed [COEF_W-1:0]   coef;
  logic signed [SAMPLE_W-1:0] opnd;
  logic                       sub;
  logic signed [ACC_W-1:0]    prod;
  logic signed [ACC_W-1:0]    acc_base;
  logic signed [SAMPLE_W-1:0] y_wb;
  logic                       accept;

  eq_coef_bank #(
    .NUM_BANDS (NUM_BANDS)
  ) u_bank (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .we_i      (coef_we),
    .wband_i   (coef_band),
    .wsel_i    (coef_sel),
    .wdata_i   (coef_wdata),
    .commit_i  (coef_commit),
    .swap_i    (state_q == IDLE),
    .pending_o (coef_pending),
    .rd_band_i (3'(band_q)),
    .rd_sel_i  (step_q),
    .rd_coef_o (coef)
  );

  assign accept = (state_q == IDLE) && sample_valid;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    band_d  = band_q;
    unique case (state_q)
      IDLE: begin
        if (sample_valid) begin
          state_d = MAC;
          step_d  = '0;
          band_d  = '0;
        end
      end
      MAC: begin
        if (step_q == 3'(SEL_A2))
          state_d = WB;
        else
          step_d = step_q + 3'd1;
      end
      WB: begin
        step_d = '0;
        if (band_q == BW'(NUM_BANDS - 1)) begin
          state_d = DONE;
        end else begin
          band_d  = band_q + BW'(1);
          state_d = MAC;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    opnd = x_q;
    sub  = 1'b0;
    unique case (step_q)
      3'(SEL_B0): opnd = x_q;
      3'(SEL_B1): opnd = x1_q[band_q];
      3'(SEL_B2): opnd = x2_q[band_q];
      3'(SEL_A1): begin
        opnd = y1_q[band_q];
        sub  = 1'b1;
      end
      3'(SEL_A2): begin
        opnd = y2_q[band_q];
        sub  = 1'b1;
      end
      default: opnd = '0;
    endcase
  end

  assign prod     = ACC_W'(coef) * ACC_W'(opnd);
  assign acc_base = (step_q == 3'd0) ? '0 : acc_q;
  assign y_wb     = sat_q16(acc_q);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      step_q    <= '0;
      band_q    <= '0;
      acc_q     <= '0;
      x_q       <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      band_q    <= band_d;
      out_vld_q <= (state_q == DONE);
      if (accept)
        x_q <= $signed(sample_in);
      else if (state_q == WB)
        x_q <= y_wb;
      if (sample_valid && (state_q != IDLE))
        ovr_q <= 1'b1;
      if (state_q == MAC)
        acc_q <= sub ? acc_base - prod : acc_base + prod;
      if (state_q == DONE)
        out_q <= x_q;
    end
  end

  // Band history only moves at write-back, after all five taps are done.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int b = 0; b < NUM_BANDS; b++) begin
        x1_q[b] <= '0;
        x2_q[b] <= '0;
        y1_q[b] <= '0;
        y2_q[b] <= '0;
      end
    end else if (state_q == WB) begin
      x2_q[band_q] <= x1_q[band_q];
      x1_q[band_q] <= x_q;
      y2_q[band_q] <= y1_q[band_q];
      y1_q[band_q] <= y_wb;
    end
  end

  assign sample_out       = out_q;
  assign sample_out_valid = out_vld_q;
  assign busy             = (state_q != IDLE);
  assign overrun          = ovr_q;

endmodule

// File: tb/tb_biquad_band_sequencer.sv
// Scoreboard bench for biquad_band_sequencer (default four bands).
// Expected outputs are queued at stimulus time and popped on each result.
module tb_biquad_band_sequencer;

  localparam int NB  = 4;
  localparam int LAT = 6 * NB + 1;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [23:0] sample_in = '0;
  logic [23:0] sample_out;
  logic        sample_out_valid;
  logic        busy;
  logic        overrun;
  logic        coef_we = 1'b0;
  logic [2:0]  coef_band = '0;
  logic [2:0]  coef_sel = '0;
  logic [17:0] coef_wdata = '0;
  logic        coef_commit = 1'b0;
  logic        coef_pending;

  int n_run  = 0;
  int n_fail = 0;
  int n_vld  = 0;

  logic [23:0] exp_q [$];

  longint mc  [NB][5];
  longint mx1 [NB];
  longint mx2 [NB];
  longint my1 [NB];
  longint my2 [NB];

  biquad_band_sequencer #(
    .NUM_BANDS (NB)
  ) dut (
    .Clk              (Clk),
    .Reset_n          (Reset_n),
    .sample_valid     (sample_valid),
    .sample_in        (sample_in),
    .sample_out       (sample_out),
    .sample_out_valid (sample_out_valid),
    .busy             (busy),
    .overrun          (overrun),
    .coef_we          (coef_we),
    .coef_band        (coef_band),
    .coef_sel         (coef_sel),
    .coef_wdata       (coef_wdata),
    .coef_commit      (coef_commit),
    .coef_pending     (coef_pending)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge Clk) begin
    #1;
    if (sample_out_valid) begin
      n_vld++;
      chk("sb_has_exp", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0)
        chk("sample_out", {8'h0, sample_out}, {8'h0, exp_q.pop_front()});
    end
  end

  function automatic logic [23:0] model(input longint xin);
    longint x, acc, y;
    x = xin;
    for (int b = 0; b < NB; b++) begin
      acc = mc[b][0] * x + mc[b][1] * mx1[b] + mc[b][2] * mx2[b]
          - mc[b][3] * my1[b] - mc[b][4] * my2[b];
      y = acc >>> 16;
      if (y > 64'sh7FFFFF) y = 64'sh7FFFFF;
      else if (y < -64'sh800000) y = -64'sh800000;
      mx2[b] = mx1[b];
      mx1[b] = x;
      my2[b] = my1[b];
      my1[b] = y;
      x = y;
    end
    return 24'(x);
  endfunction

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    for (int b = 0; b < NB; b++) begin
      for (int s = 0; s < 5; s++) mc[b][s] = (s == 0) ? 65536 : 0;
      mx1[b] = 0; mx2[b] = 0; my1[b] = 0; my2[b] = 0;
    end
    @(negedge Clk);
  endtask

  task automatic wr_coef(input int band, input int sel,
                         input logic [17:0] data);
    @(negedge Clk);
    coef_we    = 1'b1;
    coef_band  = 3'(band);
    coef_sel   = 3'(sel);
    coef_wdata = data;
`ifdef COEFF_SHADOW_EN
    coef_commit = 1'b1;
`endif
    @(negedge Clk);
    coef_we     = 1'b0;
    coef_commit = 1'b0;
    @(negedge Clk);
    if (band < NB && sel < 5)
      mc[band][sel] = longint'($signed(data));
  endtask

  task automatic send_raw(input logic [23:0] x);
    @(negedge Clk);
    sample_valid = 1'b1;
    sample_in    = x;
    @(negedge Clk);
    sample_valid = 1'b0;
  endtask

  task automatic send(input logic [23:0] x, input logic [23:0] e);
    exp_q.push_back(e);
    send_raw(x);
  endtask

  task automatic wait_done(input bit lat);
    int n = 0;
    do begin
      @(posedge Clk);
      #1;
      n++;
    end while (!sample_out_valid && n < 200);
    chk("done", 32'(sample_out_valid), 1);
    if (lat) chk("latency", n, LAT);
    @(negedge Clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int x;
    do_reset();
    chk("rst_out", {8'h0, sample_out}, 0);
    chk("rst_vld", 32'(sample_out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_pend", 32'(coef_pending), 0);

    send(24'h100000, 24'h100000);
    chk("busy_run", 32'(busy), 1);
    wait_done(1);
    chk("idle_busy", 32'(busy), 0);

    wr_coef(0, 0, 18'h1FFFF);
    send(24'h7FFFFF, 24'h7FFFFF);
    wait_done(1);
    send(24'h800000, 24'h800000);
    wait_done(1);

    do_reset();
    wr_coef(0, 1, 18'h10000);
    send(24'h001000, 24'h001000);
    wait_done(1);
    send(24'h000000, 24'h001000);
    wait_done(1);
    send(24'h000000, 24'h000000);
    wait_done(1);

    do_reset();
    wr_coef(1, 0, 18'h08000);
    wr_coef(1, 1, 18'h04000);
    wr_coef(1, 2, 18'h02000);
    wr_coef(1, 3, 18'h3A000);
    wr_coef(1, 4, 18'h01000);
    wr_coef(2, 3, 18'h02000);
    wr_coef(3, 0, 18'h18000);
    for (int i = 0; i < 8; i++) begin
      x = int'($urandom_range(0, 32'h3FFFFF)) - 32'h200000;
      send(24'(x), model(longint'(x)));
      wait_done(1);
    end

    do_reset();
    wr_coef(0, 5, 18'h00000);
    wr_coef(0, 7, 18'h00000);
    wr_coef(NB, 0, 18'h00000);
    send(24'h054321, 24'h054321);
    wait_done(1);
`ifndef COEFF_SHADOW_EN
    @(negedge Clk);
    coef_commit = 1'b1;
    @(negedge Clk);
    coef_commit = 1'b0;
    chk("pend_tied", 32'(coef_pending), 0);
`endif
    wr_coef(2, 0, 18'h08000);
    send(24'h100000, 24'h080000);
    wait_done(1);

`ifdef COEFF_SHADOW_EN
    do_reset();
    send(24'h100000, 24'h100000);
    repeat (3) @(negedge Clk);
    coef_we     = 1'b1;
    coef_band   = 3'd0;
    coef_sel    = 3'd0;
    coef_wdata  = 18'h08000;
    coef_commit = 1'b1;
    @(negedge Clk);
    coef_we     = 1'b0;
    coef_commit = 1'b0;
    chk("pend_set", 32'(coef_pending), 1);
    wait_done(0);
    chk("pend_held", 32'(coef_pending), 1);
    @(negedge Clk);
    chk("pend_clr", 32'(coef_pending), 0);
    send(24'h100000, 24'h080000);
    wait_done(1);
`endif

    do_reset();
    v0 = n_vld;
    send(24'h0ABCDE, 24'h0ABCDE);
    repeat (9) @(negedge Clk);
    sample_valid = 1'b1;
    sample_in    = 24'h123456;
    @(negedge Clk);
    sample_valid = 1'b0;
    chk("ovr_set", 32'(overrun), 1);
    repeat (40) @(negedge Clk);
    chk("ovr_one_vld", n_vld - v0, 1);
    chk("ovr_sticky", 32'(overrun), 1);

    send_raw(24'h222222);
    repeat (11) @(negedge Clk);
    v0 = n_vld;
    Reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_out", {8'h0, sample_out}, 0);
    chk("abort_ovr", 32'(overrun), 0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (40) @(negedge Clk);
    chk("abort_no_vld", n_vld - v0, 0);
    chk("abort_idle", 32'(busy), 0);

    send(24'h0F0F0F, 24'h0F0F0F);
    wait_done(1);
    repeat (2) @(negedge Clk);
    chk("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
